// File: rtl/flag_branch_ctrl_pkg.sv
// Shared encodings and helpers for the decode-stage branch sequencer.
package flag_branch_ctrl_pkg;

  // Opcode field [15:12]
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_B    = 4'hC;

  // Branch condition field [10:8]
  localparam logic [2:0] C_EQUAL            = 3'd0;
  localparam logic [2:0] C_NOT_EQUAL        = 3'd1;
  localparam logic [2:0] C_LESS             = 3'd2;
  localparam logic [2:0] C_GREATER          = 3'd3;
  localparam logic [2:0] C_OVERFLOW         = 3'd4;
  localparam logic [2:0] C_GREATER_OR_EQUAL = 3'd5;
  localparam logic [2:0] C_LESS_OR_EQUAL    = 3'd6;
  localparam logic [2:0] C_TRUE             = 3'd7;

  // Instructions that write Z/V/N when they retire
  function automatic logic is_flag_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
           (op == OP_XOR) || (op == OP_INC);
  endfunction

  // PC-relative target: offset counts 16-bit words, wraps modulo 2^16
  function automatic logic [15:0] br_target(input logic [15:0] pc, input logic [7:0] off);
    return pc + 16'd2 + {{7{off[7]}}, off, 1'b0};
  endfunction

endpackage

// File: rtl/flag_branch_ctrl_br_cond_eval.sv
// Combinational branch-condition evaluator on committed Z/V/N.
module br_cond_eval
  import flag_branch_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       taken
);

  // Map condition code to taken decision
  always_comb begin
    taken = 1'b0;
    case (cond)
      C_EQUAL:            taken = z;
      C_NOT_EQUAL:        taken = ~z;
      C_LESS:             taken = n & ~v;
      C_GREATER:          taken = ~z & ~n & ~v;
      C_OVERFLOW:         taken = v;
      C_GREATER_OR_EQUAL: taken = ~n & ~v;
      C_LESS_OR_EQUAL:    taken = (n & ~v) | z;
      C_TRUE:             taken = 1'b1;
      default:            taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Decode-stage branch sequencer: holds a conditional branch in ID until all
// in-flight flag writers have committed, resolves it, redirects fetch and
// flushes the wrong-path IF/ID slots.
module flag_branch_ctrl
  import flag_branch_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int SQUASH_CYC   = 2
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_hold,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic [15:0] id_pc,
  input  logic        flag_commit,
  input  logic        flag_z,
  input  logic        flag_v,
  input  logic        flag_n,
  output logic        stall_id,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic        br_taken,
  output logic        sb_err
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = (SQUASH_CYC > 1) ? $clog2(SQUASH_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
  localparam logic [SW-1:0] SQ_LAST = SW'(SQUASH_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESOLVE, ST_SQUASH} state_e;

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic [SW-1:0] sq_cnt;
  logic          is_br, is_fs, inc, dec, cond_taken;
  logic          unused_instr_bit;

  assign is_br = id_valid & (id_instr[15:12] == OP_B);
  assign is_fs = id_valid & is_flag_op(id_instr[15:12]);
  assign unused_instr_bit = id_instr[11];

  // Wrong-path flag writers during flush never issue, so they are not counted
  assign inc = is_fs & ~stall_id & ~pipe_hold & ~flush;
  assign dec = flag_commit;

  br_cond_eval u_cond (
    .cond  (id_instr[10:8]),
    .z     (flag_z),
    .v     (flag_v),
    .n     (flag_n),
    .taken (cond_taken)
  );

  // Scoreboard next value: saturate and flag an error on over/underflow
  always_comb begin
    cnt_nxt = cnt;
    err_nxt = 1'b0;
    if (inc && !dec) begin
      if (cnt == CNT_MAX) err_nxt = 1'b1;
      else                cnt_nxt = cnt + CW'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) err_nxt = 1'b1;
      else           cnt_nxt = cnt - CW'(1);
    end
  end

  // Scoreboard counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (err_nxt) sb_err <= 1'b1;
    end
  end

  // State register and squash-cycle counter, both frozen by pipe_hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sq_cnt <= '0;
    end else if (!pipe_hold) begin
      state  <= state_nxt;
      sq_cnt <= (state == ST_SQUASH && sq_cnt != SQ_LAST) ? sq_cnt + SW'(1) : '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (is_br) state_nxt = (cnt == '0) ? ST_RESOLVE : ST_WAIT;
      ST_WAIT:    if (!is_br)             state_nxt = ST_IDLE;
                  else if (cnt_nxt == '0) state_nxt = ST_RESOLVE;
      ST_RESOLVE: state_nxt = cond_taken ? ST_SQUASH : ST_IDLE;
      ST_SQUASH:  if (sq_cnt == SQ_LAST) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Combinational stall/flush; reset forces both low immediately
  always_comb begin
    stall_id = 1'b0;
    flush    = 1'b0;
    case (state)
      ST_IDLE:   stall_id = is_br;
      ST_WAIT:   stall_id = 1'b1;
      ST_SQUASH: flush    = 1'b1;
      default:   ;
    endcase
    if (!rst_n) begin
      stall_id = 1'b0;
      flush    = 1'b0;
    end
  end

  // Redirect pulse and target, launched as RESOLVE hands off to SQUASH;
  // held through pipe_hold so a frozen fetch still sees it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      br_taken       <= 1'b0;
      redirect_pc    <= '0;
    end else if (!pipe_hold) begin
      redirect_valid <= 1'b0;
      br_taken       <= 1'b0;
      if (state == ST_RESOLVE && cond_taken) begin
        redirect_valid <= 1'b1;
        br_taken       <= 1'b1;
        redirect_pc    <= br_target(id_pc, id_instr[7:0]);
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Bench for flag_branch_ctrl: condition/target table, hand-written
// multi-cycle corner sequences and a randomized run against a cycle-event model.
module tb_flag_branch_ctrl;
  import flag_branch_ctrl_pkg::*;

  localparam int MAXI = 3;
  localparam int SQ   = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pipe_hold, id_valid, flag_commit, flag_z, flag_v, flag_n;
  logic [15:0] id_instr, id_pc;
  logic        stall_id, redirect_valid, flush, br_taken, sb_err;
  logic [15:0] redirect_pc;

  int total = 0, bad = 0;

  flag_branch_ctrl #(.MAX_INFLIGHT(MAXI), .SQUASH_CYC(SQ)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .flag_commit(flag_commit),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .stall_id(stall_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .br_taken(br_taken), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cond; logic z, v, n; logic [15:0] pc; logic [7:0] off;
    logic taken; logic [15:0] tgt;
  } vec_t;
  vec_t vt[18];

  function automatic logic [15:0] mk_b(input logic [2:0] c, input logic [7:0] o);
    return {OP_B, 1'b0, c, o};
  endfunction

  function automatic logic [15:0] mk_op(input logic [3:0] op);
    return {op, 12'h123};
  endfunction

  // Spec-level condition truth
  function automatic logic ref_cond(input logic [2:0] c, input logic z, v, n);
    case (c)
      C_EQUAL:            return z;
      C_NOT_EQUAL:        return !z;
      C_LESS:             return n && !v;
      C_GREATER:          return !z && !n && !v;
      C_OVERFLOW:         return v;
      C_GREATER_OR_EQUAL: return !n && !v;
      C_LESS_OR_EQUAL:    return (n && !v) || z;
      default:            return 1'b1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic clr_in;
    pipe_hold = 0; id_valid = 0; id_instr = 0; id_pc = 0;
    flag_commit = 0; flag_z = 0; flag_v = 0; flag_n = 0;
  endtask

  task automatic do_reset;
    rst_n = 0; clr_in();
    #1;
    chk("rst_stall", {15'd0, stall_id}, 16'd0);
    chk("rst_redir", {15'd0, redirect_valid}, 16'd0);
    chk("rst_flush", {15'd0, flush}, 16'd0);
    chk("rst_sberr", {15'd0, sb_err}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // One branch with an empty scoreboard: 1 stall, resolve, optional redirect+flush
  task automatic run_branch(input int idx, input vec_t v);
    step(); id_valid = 1; id_instr = mk_b(v.cond, v.off); id_pc = v.pc;
    flag_z = v.z; flag_v = v.v; flag_n = v.n; #1;
    chk($sformatf("v%0d_stall", idx), {15'd0, stall_id}, 16'd1);
    step(); #1;
    chk($sformatf("v%0d_resolve_nostall", idx), {15'd0, stall_id}, 16'd0);
    step(); id_valid = 0; #1;
    chk($sformatf("v%0d_redir", idx), {15'd0, redirect_valid}, {15'd0, v.taken});
    chk($sformatf("v%0d_taken", idx), {15'd0, br_taken}, {15'd0, v.taken});
    chk($sformatf("v%0d_flush1", idx), {15'd0, flush}, {15'd0, v.taken});
    if (v.taken) chk($sformatf("v%0d_pc", idx), redirect_pc, v.tgt);
    step(); #1;
    chk($sformatf("v%0d_flush2", idx), {15'd0, flush}, {15'd0, v.taken});
    chk($sformatf("v%0d_redir_off", idx), {15'd0, redirect_valid}, 16'd0);
    step(); #1;
    chk($sformatf("v%0d_flush_off", idx), {15'd0, flush}, 16'd0);
  endtask

  // Randomized-run model state: counts plus cycle-stamped events
  int m_cnt, cyc, m_flush_end, m_redir_at;
  logic m_err, m_wait, m_resolve;
  logic [15:0] m_target;

  task automatic model_cycle;
    logic ib, fs, flushing, exp_redir, exp_stall, counted;
    int old_cnt;
    ib = id_valid && id_instr[15:12] == OP_B;
    fs = id_valid && is_flag_op(id_instr[15:12]);
    flushing  = (cyc <= m_flush_end);
    exp_redir = (cyc == m_redir_at);
    if (m_resolve || flushing) exp_stall = 0;
    else if (m_wait)           exp_stall = 1;
    else                       exp_stall = ib;
    chk("rnd_stall", {15'd0, stall_id}, {15'd0, exp_stall});
    chk("rnd_flush", {15'd0, flush}, {15'd0, flushing});
    chk("rnd_redir", {15'd0, redirect_valid}, {15'd0, exp_redir});
    chk("rnd_brtaken", {15'd0, br_taken}, {15'd0, exp_redir});
    if (exp_redir) chk("rnd_pc", redirect_pc, m_target);
    chk("rnd_sberr", {15'd0, sb_err}, {15'd0, m_err});
    old_cnt = m_cnt;
    counted = fs && !exp_stall && !flushing;
    if (counted && !flag_commit) begin
      if (m_cnt == MAXI) m_err = 1; else m_cnt++;
    end else if (flag_commit && !counted) begin
      if (m_cnt == 0) m_err = 1; else m_cnt--;
    end
    if (m_resolve) begin
      m_resolve = 0;
      if (ref_cond(id_instr[10:8], flag_z, flag_v, flag_n)) begin
        m_redir_at  = cyc + 1;
        m_flush_end = cyc + SQ;
        m_target    = id_pc + 16'd2 + 16'(2 * $signed(id_instr[7:0]));
      end
    end else if (flushing) begin
      // branch-ordering is suspended while wrong-path slots drain
    end else if (m_wait) begin
      if (!ib) m_wait = 0;
      else if (m_cnt == 0) begin m_wait = 0; m_resolve = 1; end
    end else if (ib) begin
      if (old_cnt == 0) m_resolve = 1; else m_wait = 1;
    end
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{C_TRUE,             0,0,0, 16'h0100, 8'h04, 1, 16'h010A};
    vt[1]  = '{C_NOT_EQUAL,        1,0,0, 16'h0100, 8'h04, 0, 16'h0000};
    vt[2]  = '{C_TRUE,             0,0,0, 16'h0000, 8'hFE, 1, 16'hFFFE};
    vt[3]  = '{C_EQUAL,            1,0,0, 16'h1000, 8'h10, 1, 16'h1022};
    vt[4]  = '{C_EQUAL,            0,0,0, 16'h1000, 8'h10, 0, 16'h0000};
    vt[5]  = '{C_NOT_EQUAL,        0,0,0, 16'h2000, 8'h80, 1, 16'h1F02};
    vt[6]  = '{C_LESS,             0,0,1, 16'h0010, 8'h01, 1, 16'h0014};
    vt[7]  = '{C_LESS,             0,1,1, 16'h0010, 8'h01, 0, 16'h0000};
    vt[8]  = '{C_GREATER,          0,0,0, 16'hFFFE, 8'h00, 1, 16'h0000};
    vt[9]  = '{C_GREATER,          1,0,0, 16'hFFFE, 8'h00, 0, 16'h0000};
    vt[10] = '{C_OVERFLOW,         0,1,0, 16'h3000, 8'h7F, 1, 16'h3100};
    vt[11] = '{C_OVERFLOW,         0,0,0, 16'h3000, 8'h7F, 0, 16'h0000};
    vt[12] = '{C_GREATER_OR_EQUAL, 0,0,0, 16'h0200, 8'hFF, 1, 16'h0200};
    vt[13] = '{C_GREATER_OR_EQUAL, 0,0,1, 16'h0200, 8'hFF, 0, 16'h0000};
    vt[14] = '{C_LESS_OR_EQUAL,    1,0,0, 16'h0400, 8'h02, 1, 16'h0406};
    vt[15] = '{C_LESS_OR_EQUAL,    0,1,0, 16'h0400, 8'h02, 0, 16'h0000};
    vt[16] = '{C_LESS_OR_EQUAL,    0,0,1, 16'h0500, 8'h03, 1, 16'h0508};
    vt[17] = '{C_GREATER_OR_EQUAL, 0,1,1, 16'h0500, 8'h03, 0, 16'h0000};

    clr_in();
    do_reset();
    for (int i = 0; i < 18; i++) run_branch(i, vt[i]);

    // Flag writer ahead of branch: WAIT until its commit, then taken redirect
    do_reset();
    step(); id_valid = 1; id_instr = mk_op(OP_ADD); #1;
    chk("s2_add_nostall", {15'd0, stall_id}, 16'd0);
    step(); id_instr = mk_b(C_EQUAL, 8'h08); id_pc = 16'h0200; flag_z = 0; #1;
    chk("s2_stall0", {15'd0, stall_id}, 16'd1);
    step(); #1; chk("s2_wait1", {15'd0, stall_id}, 16'd1);
    step(); #1; chk("s2_wait2", {15'd0, stall_id}, 16'd1);
    step(); flag_commit = 1; flag_z = 1; #1;
    chk("s2_wait_commit", {15'd0, stall_id}, 16'd1);
    step(); flag_commit = 0; #1;
    chk("s2_resolve", {15'd0, stall_id}, 16'd0);
    chk("s2_no_redir_yet", {15'd0, redirect_valid}, 16'd0);
    step(); id_valid = 0; #1;
    chk("s2_redir", {15'd0, redirect_valid}, 16'd1);
    chk("s2_pc", redirect_pc, 16'h0212);
    step(); step(); step(); #1;
    chk("s2_idle", {15'd0, flush}, 16'd0);

    // Issue+commit same cycle keeps cnt; then drain and underflow once
    do_reset();
    step(); id_valid = 1; id_instr = mk_op(OP_SUB);
    step(); id_instr = mk_op(OP_XOR); flag_commit = 1;
    step(); id_valid = 0;
    step(); flag_commit = 0; #1;
    chk("s5_no_err_at_zero", {15'd0, sb_err}, 16'd0);
    flag_commit = 1;
    step(); flag_commit = 0; #1;
    chk("s5_underflow_err", {15'd0, sb_err}, 16'd1);
    step(); step(); #1;
    chk("s5_sticky", {15'd0, sb_err}, 16'd1);

    // Overflow saturates at MAX: branch must still wait for three commits
    do_reset();
    step(); id_valid = 1; id_instr = mk_op(OP_INC);
    step(); step(); step();
    step(); id_instr = mk_b(C_TRUE, 8'h01); id_pc = 16'h0300; #1;
    chk("ovf_err", {15'd0, sb_err}, 16'd1);
    chk("ovf_stall", {15'd0, stall_id}, 16'd1);
    for (int k = 0; k < 3; k++) begin
      step(); flag_commit = 1; #1;
      chk($sformatf("ovf_wait%0d", k), {15'd0, stall_id}, 16'd1);
    end
    step(); flag_commit = 0; #1;
    chk("ovf_resolve", {15'd0, stall_id}, 16'd0);
    step(); id_valid = 0; #1;
    chk("ovf_redir", {15'd0, redirect_valid}, 16'd1);
    chk("ovf_pc", redirect_pc, 16'h0304);
    step(); step();

    // pipe_hold freezes RESOLVE
    do_reset();
    step(); id_valid = 1; id_instr = mk_b(C_TRUE, 8'h10); id_pc = 16'h0040; #1;
    chk("hold_stall", {15'd0, stall_id}, 16'd1);
    step(); pipe_hold = 1; #1;
    chk("hold_resolve_nostall", {15'd0, stall_id}, 16'd0);
    step(); #1;
    chk("hold_no_redir", {15'd0, redirect_valid}, 16'd0);
    step(); pipe_hold = 0; #1;
    chk("hold_release_no_redir", {15'd0, redirect_valid}, 16'd0);
    step(); id_valid = 0; #1;
    chk("hold_redir", {15'd0, redirect_valid}, 16'd1);
    chk("hold_pc", redirect_pc, 16'h0062);
    step(); step(); #1;
    chk("hold_flush_off", {15'd0, flush}, 16'd0);

    // id_valid drops while waiting: no resolve afterwards
    do_reset();
    step(); id_valid = 1; id_instr = mk_op(OP_NAND);
    step(); id_instr = mk_b(C_TRUE, 8'h02); #1;
    chk("drop_stall", {15'd0, stall_id}, 16'd1);
    step(); id_valid = 0; #1;
    chk("drop_wait_stall", {15'd0, stall_id}, 16'd1);
    step(); flag_commit = 1; #1;
    chk("drop_idle", {15'd0, stall_id}, 16'd0);
    step(); flag_commit = 0; #1;
    chk("drop_no_redir1", {15'd0, redirect_valid}, 16'd0);
    step(); #1;
    chk("drop_no_redir2", {15'd0, redirect_valid}, 16'd0);
    chk("drop_no_flush", {15'd0, flush}, 16'd0);
    chk("drop_no_err", {15'd0, sb_err}, 16'd0);

    // Reset mid-flush clears outputs before the next edge
    do_reset();
    step(); id_valid = 1; id_instr = mk_b(C_TRUE, 8'h04); id_pc = 16'h0100;
    step();
    step(); #1;
    chk("r6_flush_on", {15'd0, flush}, 16'd1);
    rst_n = 0; #1;
    chk("r6_flush_rst", {15'd0, flush}, 16'd0);
    chk("r6_stall_rst", {15'd0, stall_id}, 16'd0);
    chk("r6_redir_rst", {15'd0, redirect_valid}, 16'd0);
    chk("r6_taken_rst", {15'd0, br_taken}, 16'd0);
    step(); rst_n = 1; #1;
    chk("r6_idle_stall", {15'd0, stall_id}, 16'd1);
    chk("r6_idle_flush", {15'd0, flush}, 16'd0);
    step(); step(); id_valid = 0; #1;
    chk("r6_redir_after", {15'd0, redirect_valid}, 16'd1);
    step(); step();

    // Randomized run against the event model
    do_reset();
    m_cnt = 0; m_err = 0; m_wait = 0; m_resolve = 0;
    cyc = 0; m_flush_end = -1; m_redir_at = -1; m_target = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (m_wait || m_resolve) begin
        id_valid = m_wait ? ($urandom_range(0, 19) != 0) : 1'b1;
      end else begin
        int sel;
        logic [3:0] op;
        sel = $urandom_range(0, 9);
        case (sel)
          0: op = OP_ADD;  1: op = OP_SUB;  2: op = OP_NAND;
          3: op = OP_XOR;  4: op = OP_INC;  8: op = OP_MOV;
          9: op = OP_LD;   default: op = OP_B;
        endcase
        id_valid = ($urandom_range(0, 4) != 0);
        id_instr = {op, 12'($urandom)};
        id_pc    = 16'($urandom);
      end
      flag_z = 1'($urandom); flag_v = 1'($urandom); flag_n = 1'($urandom);
      flag_commit = (m_cnt > 0) && ($urandom_range(0, 1) == 0);
      #1;
      model_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
